// File: rtl/axi_dma_burst_engine.sv
// AXI4 master burst engine: turns DMA read/write block commands into INCR bursts.
// The read and write planes are fully independent FSMs sharing only clk/rstn.
module axi_dma_burst_engine #(
    parameter int AXI_WIDTH_AD  = 32,
    parameter int AXI_WIDTH_DA  = 32,
    parameter int BIT_TRANS     = 18,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    // read command / data plane
    input  logic                      i_ctrl_read,
    input  logic [AXI_WIDTH_AD-1:0]   i_read_addr,
    input  logic [BIT_TRANS-1:0]      i_rd_num_trans,
    output logic                      o_read_done,
    output logic                      o_rd_busy,
    output logic [AXI_WIDTH_DA-1:0]   o_rd_data,
    output logic                      o_rd_data_vld,
    input  logic                      i_rd_data_rdy,
    output logic                      o_rd_err,
    // write command / data plane
    input  logic                      i_ctrl_write,
    input  logic [AXI_WIDTH_AD-1:0]   i_write_addr,
    input  logic [BIT_TRANS-1:0]      i_wr_num_trans,
    output logic                      o_indata_req_wr,
    input  logic [AXI_WIDTH_DA-1:0]   i_wr_data,
    output logic                      o_write_done,
    output logic                      o_wr_busy,
    output logic                      o_wr_err,
    // AXI AR
    output logic [AXI_WIDTH_AD-1:0]   o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    // AXI R
    input  logic [AXI_WIDTH_DA-1:0]   i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    // AXI AW
    output logic [AXI_WIDTH_AD-1:0]   o_awaddr,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    // AXI W
    output logic [AXI_WIDTH_DA-1:0]   o_wdata,
    output logic [AXI_WIDTH_DA/8-1:0] o_wstrb,
    output logic                      o_wlast,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    // AXI B
    input  logic [1:0]                i_bresp,
    input  logic                      i_bvalid,
    output logic                      o_bready,
    // FSM state for debug/checkers
    output logic [1:0]                o_rd_state,
    output logic [2:0]                o_wr_state
);

    localparam int BPB = AXI_WIDTH_DA / 8;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // a valid, once raised, holds with stable payload until that edge.

    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R, RD_DONE} rd_state_t;
    typedef enum logic [2:0] {WR_IDLE, WR_AW, WR_REQ, WR_CAP, WR_SEND, WR_BWAIT, WR_DONE} wr_state_t;

    rd_state_t              rd_state;
    logic [AXI_WIDTH_AD-1:0] rd_addr;
    logic [BIT_TRANS-1:0]    rd_rem;
    logic [8:0]              rd_len;
    logic [8:0]              rd_cnt;

    wr_state_t              wr_state;
    logic [AXI_WIDTH_AD-1:0] wr_addr;
    logic [BIT_TRANS-1:0]    wr_rem;
    logic [8:0]              wr_len;
    logic [8:0]              wr_cnt;

    function automatic logic [8:0] burst_len(input logic [BIT_TRANS-1:0] rem);
        if (rem > BIT_TRANS'(MAX_BURST_LEN))
            return 9'(MAX_BURST_LEN);
        else
            return 9'(rem);
    endfunction

    function automatic logic [AXI_WIDTH_AD-1:0] burst_bytes(input logic [8:0] len);
        return AXI_WIDTH_AD'(len) << $clog2(BPB);
    endfunction

    assign o_arsize   = 3'($clog2(BPB));
    assign o_awsize   = 3'($clog2(BPB));
    assign o_arburst  = 2'b01;
    assign o_awburst  = 2'b01;
    assign o_wstrb    = '1;
    assign o_rd_busy  = (rd_state != RD_IDLE);
    assign o_wr_busy  = (wr_state != WR_IDLE);
    assign o_rd_state = rd_state;
    assign o_wr_state = wr_state;

    // R is a combinational pass-through so downstream back-pressure reaches the slave directly.
    assign o_rready      = (rd_state == RD_R) && i_rd_data_rdy;
    assign o_rd_data_vld = (rd_state == RD_R) && i_rvalid;
    assign o_rd_data     = i_rdata;

    logic rd_beat;
    logic rd_last;
    assign rd_beat = (rd_state == RD_R) && i_rvalid && i_rd_data_rdy;
    assign rd_last = (rd_cnt == rd_len - 9'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state    <= RD_IDLE;
            rd_addr     <= '0;
            rd_rem      <= '0;
            rd_len      <= '0;
            rd_cnt      <= '0;
            o_araddr    <= '0;
            o_arlen     <= '0;
            o_arvalid   <= 1'b0;
            o_read_done <= 1'b0;
            o_rd_err    <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (i_ctrl_read) begin
                        o_rd_err <= 1'b0;
                        rd_addr  <= i_read_addr;
                        rd_rem   <= i_rd_num_trans;
                        if (i_rd_num_trans == '0) begin
                            o_read_done <= 1'b1;
                            rd_state    <= RD_DONE;
                        end else begin
                            o_arvalid <= 1'b1;
                            o_araddr  <= i_read_addr;
                            o_arlen   <= 8'(burst_len(i_rd_num_trans) - 9'd1);
                            rd_len    <= burst_len(i_rd_num_trans);
                            rd_state  <= RD_AR;
                        end
                    end
                end
                RD_AR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        rd_addr   <= rd_addr + burst_bytes(rd_len);
                        rd_rem    <= rd_rem - BIT_TRANS'(rd_len);
                        rd_cnt    <= '0;
                        rd_state  <= RD_R;
                    end
                end
                RD_R: begin
                    if (rd_beat) begin
                        rd_cnt <= rd_cnt + 9'd1;
                        // The beat counter ends the burst; a misplaced rlast only flags an error.
                        if (i_rresp != 2'b00 || i_rlast != rd_last)
                            o_rd_err <= 1'b1;
                        if (rd_last) begin
                            if (rd_rem != '0) begin
                                o_arvalid <= 1'b1;
                                o_araddr  <= rd_addr;
                                o_arlen   <= 8'(burst_len(rd_rem) - 9'd1);
                                rd_len    <= burst_len(rd_rem);
                                rd_state  <= RD_AR;
                            end else begin
                                o_read_done <= 1'b1;
                                rd_state    <= RD_DONE;
                            end
                        end
                    end
                end
                RD_DONE: begin
                    o_read_done <= 1'b0;
                    rd_state    <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state        <= WR_IDLE;
            wr_addr         <= '0;
            wr_rem          <= '0;
            wr_len          <= '0;
            wr_cnt          <= '0;
            o_awaddr        <= '0;
            o_awlen         <= '0;
            o_awvalid       <= 1'b0;
            o_indata_req_wr <= 1'b0;
            o_wdata         <= '0;
            o_wlast         <= 1'b0;
            o_wvalid        <= 1'b0;
            o_bready        <= 1'b0;
            o_write_done    <= 1'b0;
            o_wr_err        <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (i_ctrl_write) begin
                        o_wr_err <= 1'b0;
                        wr_addr  <= i_write_addr;
                        wr_rem   <= i_wr_num_trans;
                        if (i_wr_num_trans == '0) begin
                            o_write_done <= 1'b1;
                            wr_state     <= WR_DONE;
                        end else begin
                            o_awvalid <= 1'b1;
                            o_awaddr  <= i_write_addr;
                            o_awlen   <= 8'(burst_len(i_wr_num_trans) - 9'd1);
                            wr_len    <= burst_len(i_wr_num_trans);
                            wr_state  <= WR_AW;
                        end
                    end
                end
                WR_AW: begin
                    if (i_awready) begin
                        o_awvalid       <= 1'b0;
                        wr_addr         <= wr_addr + burst_bytes(wr_len);
                        wr_rem          <= wr_rem - BIT_TRANS'(wr_len);
                        wr_cnt          <= '0;
                        o_indata_req_wr <= 1'b1;
                        wr_state        <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    o_indata_req_wr <= 1'b0;
                    wr_state        <= WR_CAP;
                end
                // Buffer data arrives one cycle after the request pulse.
                WR_CAP: begin
                    o_wdata  <= i_wr_data;
                    o_wvalid <= 1'b1;
                    o_wlast  <= (wr_cnt == wr_len - 9'd1);
                    wr_state <= WR_SEND;
                end
                WR_SEND: begin
                    if (i_wready) begin
                        o_wvalid <= 1'b0;
                        o_wlast  <= 1'b0;
                        wr_cnt   <= wr_cnt + 9'd1;
                        if (o_wlast) begin
                            o_bready <= 1'b1;
                            wr_state <= WR_BWAIT;
                        end else begin
                            o_indata_req_wr <= 1'b1;
                            wr_state        <= WR_REQ;
                        end
                    end
                end
                WR_BWAIT: begin
                    if (i_bvalid) begin
                        o_bready <= 1'b0;
                        if (i_bresp != 2'b00)
                            o_wr_err <= 1'b1;
                        if (wr_rem != '0) begin
                            o_awvalid <= 1'b1;
                            o_awaddr  <= wr_addr;
                            o_awlen   <= 8'(burst_len(wr_rem) - 9'd1);
                            wr_len    <= burst_len(wr_rem);
                            wr_state  <= WR_AW;
                        end else begin
                            o_write_done <= 1'b1;
                            wr_state     <= WR_DONE;
                        end
                    end
                end
                WR_DONE: begin
                    o_write_done <= 1'b0;
                    wr_state     <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_burst_engine.sv
// Bench for axi_dma_burst_engine: randomized AXI slave plus a burst/data reference model.
`timescale 1ns/1ps
module tb_axi_dma_burst_engine;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BT  = 18;
    localparam int MBL = 16;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic          i_ctrl_read, i_ctrl_write;
    logic [AW-1:0] i_read_addr, i_write_addr;
    logic [BT-1:0] i_rd_num_trans, i_wr_num_trans;
    logic          o_read_done, o_rd_busy, o_rd_data_vld, i_rd_data_rdy, o_rd_err;
    logic [DW-1:0] o_rd_data;
    logic          o_indata_req_wr, o_write_done, o_wr_busy, o_wr_err;
    logic [DW-1:0] i_wr_data;
    logic [AW-1:0] o_araddr, o_awaddr;
    logic [7:0]    o_arlen, o_awlen;
    logic [2:0]    o_arsize, o_awsize;
    logic [1:0]    o_arburst, o_awburst;
    logic          o_arvalid, i_arready, o_awvalid, i_awready;
    logic [DW-1:0] i_rdata, o_wdata;
    logic [1:0]    i_rresp, i_bresp;
    logic          i_rlast, i_rvalid, o_rready;
    logic [DW/8-1:0] o_wstrb;
    logic          o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
    logic [1:0]    o_rd_state;
    logic [2:0]    o_wr_state;

    axi_dma_burst_engine #(
        .AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW), .BIT_TRANS(BT), .MAX_BURST_LEN(MBL)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_ctrl_read(i_ctrl_read), .i_read_addr(i_read_addr), .i_rd_num_trans(i_rd_num_trans),
        .o_read_done(o_read_done), .o_rd_busy(o_rd_busy), .o_rd_data(o_rd_data),
        .o_rd_data_vld(o_rd_data_vld), .i_rd_data_rdy(i_rd_data_rdy), .o_rd_err(o_rd_err),
        .i_ctrl_write(i_ctrl_write), .i_write_addr(i_write_addr), .i_wr_num_trans(i_wr_num_trans),
        .o_indata_req_wr(o_indata_req_wr), .i_wr_data(i_wr_data), .o_write_done(o_write_done),
        .o_wr_busy(o_wr_busy), .o_wr_err(o_wr_err),
        .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_rd_state(o_rd_state), .o_wr_state(o_wr_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_pass = 0;
    int n_total = 0;

    // slave configuration (0 = always ready/valid, otherwise randomized)
    int ar_mode, r_mode, aw_mode, w_mode, b_mode;
    int rlast_inj, rresp_inj;
    logic [1:0] bresp_inj;
    bit w_idx_mode;

    // observations and expected-data queues
    logic [AW-1:0] obs_ar_addr[$], obs_aw_addr[$];
    logic [7:0]    obs_ar_len[$], obs_aw_len[$];
    logic [4:0]    obs_ar_meta[$], obs_aw_meta[$];
    logic [DW-1:0] obs_rd_data[$], obs_w_data[$];
    logic          obs_w_last[$];
    logic [DW-1:0] exp_rd_q[$], exp_wr_q[$];

    int unsigned cyc = 0;
    int rd_done_cnt = 0, wr_done_cnt = 0, wreq_cnt = 0;
    int unsigned rd_done_cyc, wr_done_cyc, last_rbeat_cyc, last_b_cyc, rd_cmd_cyc, wr_cmd_cyc;
    bit arvalid_seen, awvalid_seen;

    // slave-side state
    int r_beats_q[$];
    int r_left = 0, r_len = 0, r_idx = 0, r_gbeat = 0, b_pend = 0, w_idx = 0;
    bit w_toggle = 1'b0;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wreq_s;
    logic [AW-1:0] ar_addr_s, aw_addr_s;
    logic [7:0]    ar_len_s, aw_len_s;
    logic [4:0]    ar_meta_s, aw_meta_s;
    logic [DW-1:0] w_data_s;
    logic          w_last_s;

    // ---------------- AXI slave + local buffer responder ----------------
    // Inputs change on the falling edge; everything is sampled 1ns later and
    // the transfers seen there take effect at the following rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            i_arready = 0; i_rvalid = 0; i_rlast = 0; i_rresp = 0; i_rdata = '0;
            i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0; i_rd_data_rdy = 0;
            r_beats_q.delete(); r_left = 0; b_pend = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; wreq_s = 0;
        end else begin
            cyc++;
            if (ar_hs) begin
                obs_ar_addr.push_back(ar_addr_s);
                obs_ar_len.push_back(ar_len_s);
                obs_ar_meta.push_back(ar_meta_s);
                r_beats_q.push_back(int'(ar_len_s) + 1);
            end
            if (r_hs) begin
                i_rvalid = 0;
                r_left--;
                r_idx++;
            end
            if (aw_hs) begin
                obs_aw_addr.push_back(aw_addr_s);
                obs_aw_len.push_back(aw_len_s);
                obs_aw_meta.push_back(aw_meta_s);
            end
            if (w_hs) begin
                obs_w_data.push_back(w_data_s);
                obs_w_last.push_back(w_last_s);
                if (w_last_s) b_pend++;
            end
            if (b_hs) begin
                i_bvalid = 0;
                b_pend--;
            end
            if (wreq_s) begin
                i_wr_data = w_idx_mode ? DW'(w_idx) : DW'($urandom);
                exp_wr_q.push_back(i_wr_data);
                w_idx++;
            end

            i_arready     = (ar_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_awready     = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_rd_data_rdy = (r_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            w_toggle      = ~w_toggle;
            i_wready      = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? w_toggle : 1'($urandom_range(0, 1));

            if (r_left == 0 && r_beats_q.size() > 0) begin
                r_left = r_beats_q.pop_front();
                r_len  = r_left;
                r_idx  = 0;
            end
            if (!i_rvalid && r_left > 0 && (r_mode == 0 || $urandom_range(0, 3) != 0)) begin
                i_rvalid = 1;
                i_rdata  = $urandom;
                i_rlast  = (r_idx == r_len - 1);
                i_rresp  = 2'b00;
                if (r_gbeat == rlast_inj) i_rlast = 1;
                if (r_gbeat == rresp_inj) i_rresp = 2'b10;
                exp_rd_q.push_back(i_rdata);
                r_gbeat++;
            end
            if (!i_bvalid && b_pend > 0 && (b_mode == 0 || $urandom_range(0, 2) == 0)) begin
                i_bvalid = 1;
                i_bresp  = bresp_inj;
            end

            #1;
            ar_hs = o_arvalid && i_arready;
            ar_addr_s = o_araddr; ar_len_s = o_arlen; ar_meta_s = {o_arsize, o_arburst};
            if (o_arvalid) arvalid_seen = 1;
            r_hs = i_rvalid && o_rready;
            if (o_rd_data_vld && i_rd_data_rdy) begin
                obs_rd_data.push_back(o_rd_data);
                last_rbeat_cyc = cyc;
            end
            aw_hs = o_awvalid && i_awready;
            aw_addr_s = o_awaddr; aw_len_s = o_awlen; aw_meta_s = {o_awsize, o_awburst};
            if (o_awvalid) awvalid_seen = 1;
            w_hs = o_wvalid && i_wready;
            w_data_s = o_wdata; w_last_s = o_wlast;
            b_hs = i_bvalid && o_bready;
            if (b_hs) last_b_cyc = cyc;
            wreq_s = o_indata_req_wr;
            if (wreq_s) wreq_cnt++;
            if (o_read_done) begin rd_done_cnt++; rd_done_cyc = cyc; end
            if (o_write_done) begin wr_done_cnt++; wr_done_cyc = cyc; end
            if (i_ctrl_read) rd_cmd_cyc = cyc;
            if (i_ctrl_write) wr_cmd_cyc = cyc;
        end
    end

    // ---------------- checking and driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic setup(input int arm, input int rm, input int awm, input int wm, input int bm);
        @(posedge clk);
        obs_ar_addr.delete(); obs_ar_len.delete(); obs_ar_meta.delete();
        obs_aw_addr.delete(); obs_aw_len.delete(); obs_aw_meta.delete();
        obs_rd_data.delete(); obs_w_data.delete(); obs_w_last.delete();
        exp_rd_q.delete(); exp_wr_q.delete();
        arvalid_seen = 0; awvalid_seen = 0; wreq_cnt = 0; r_gbeat = 0; w_idx = 0;
        ar_mode = arm; r_mode = rm; aw_mode = awm; w_mode = wm; b_mode = bm;
        rlast_inj = -1; rresp_inj = -1; bresp_inj = 2'b00; w_idx_mode = 0;
    endtask

    task automatic send_cmd(input bit do_rd, input logic [AW-1:0] ra, input int rn,
                            input bit do_wr, input logic [AW-1:0] wa, input int wn);
        @(negedge clk);
        i_ctrl_read = do_rd;  i_read_addr = ra;  i_rd_num_trans = BT'(rn);
        i_ctrl_write = do_wr; i_write_addr = wa; i_wr_num_trans = BT'(wn);
        @(negedge clk);
        i_ctrl_read = 0; i_ctrl_write = 0;
    endtask

    task automatic wait_done(input int rd_base, input int wr_base, input bit want_rd, input bit want_wr);
        int k = 0;
        while (k < BUDGET && ((want_rd && rd_done_cnt == rd_base) || (want_wr && wr_done_cnt == wr_base))) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 64'(k < BUDGET), 1);
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic check_read(input string tag, input logic [AW-1:0] addr, input int n,
                              input logic exp_err, input int done_base);
        logic [AW-1:0] m_addr[$];
        logic [7:0]    m_len[$];
        logic [AW-1:0] a;
        int rem, len, nb;
        a = addr; rem = n;
        while (rem > 0) begin
            len = (rem > MBL) ? MBL : rem;
            m_addr.push_back(a);
            m_len.push_back(8'(len - 1));
            a = a + AW'(len * (DW / 8));
            rem -= len;
        end
        chk({tag, ":ar_count"}, obs_ar_addr.size(), m_addr.size());
        nb = (obs_ar_addr.size() < m_addr.size()) ? obs_ar_addr.size() : m_addr.size();
        for (int i = 0; i < nb; i++) begin
            chk({tag, ":araddr"}, obs_ar_addr[i], m_addr[i]);
            chk({tag, ":arlen"}, obs_ar_len[i], m_len[i]);
            chk({tag, ":arsize_burst"}, obs_ar_meta[i], {3'd2, 2'b01});
        end
        chk({tag, ":rd_beats"}, obs_rd_data.size(), n);
        nb = (obs_rd_data.size() < exp_rd_q.size()) ? obs_rd_data.size() : exp_rd_q.size();
        for (int i = 0; i < nb; i++)
            chk({tag, ":rd_data"}, obs_rd_data[i], exp_rd_q[i]);
        chk({tag, ":read_done_count"}, rd_done_cnt - done_base, 1);
        if (n > 0) begin
            chk({tag, ":read_done_timing"}, rd_done_cyc, last_rbeat_cyc + 1);
        end else begin
            chk({tag, ":read_done_timing"}, rd_done_cyc, rd_cmd_cyc + 1);
            chk({tag, ":arvalid_never"}, arvalid_seen, 0);
        end
        chk({tag, ":rd_err"}, o_rd_err, exp_err);
        chk({tag, ":rd_busy"}, o_rd_busy, 0);
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] addr, input int n,
                               input logic exp_err, input int done_base);
        logic [AW-1:0] m_addr[$];
        logic [7:0]    m_len[$];
        logic          m_last[$];
        logic [AW-1:0] a;
        int rem, len, nb;
        a = addr; rem = n;
        while (rem > 0) begin
            len = (rem > MBL) ? MBL : rem;
            m_addr.push_back(a);
            m_len.push_back(8'(len - 1));
            for (int j = 0; j < len; j++) m_last.push_back(j == len - 1);
            a = a + AW'(len * (DW / 8));
            rem -= len;
        end
        chk({tag, ":aw_count"}, obs_aw_addr.size(), m_addr.size());
        nb = (obs_aw_addr.size() < m_addr.size()) ? obs_aw_addr.size() : m_addr.size();
        for (int i = 0; i < nb; i++) begin
            chk({tag, ":awaddr"}, obs_aw_addr[i], m_addr[i]);
            chk({tag, ":awlen"}, obs_aw_len[i], m_len[i]);
            chk({tag, ":awsize_burst"}, obs_aw_meta[i], {3'd2, 2'b01});
        end
        chk({tag, ":req_pulses"}, wreq_cnt, n);
        chk({tag, ":w_beats"}, obs_w_data.size(), n);
        nb = (obs_w_data.size() < exp_wr_q.size()) ? obs_w_data.size() : exp_wr_q.size();
        if (nb > m_last.size()) nb = m_last.size();
        for (int i = 0; i < nb; i++) begin
            chk({tag, ":wdata"}, obs_w_data[i], exp_wr_q[i]);
            chk({tag, ":wlast"}, obs_w_last[i], m_last[i]);
            if (w_idx_mode) chk({tag, ":wdata_index"}, obs_w_data[i], i);
        end
        chk({tag, ":write_done_count"}, wr_done_cnt - done_base, 1);
        if (n > 0) begin
            chk({tag, ":write_done_timing"}, wr_done_cyc, last_b_cyc + 1);
        end else begin
            chk({tag, ":write_done_timing"}, wr_done_cyc, wr_cmd_cyc + 1);
            chk({tag, ":awvalid_never"}, awvalid_seen, 0);
        end
        chk({tag, ":wr_err"}, o_wr_err, exp_err);
        chk({tag, ":wr_busy"}, o_wr_busy, 0);
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int rb, wb;
        logic [AW-1:0] ra, wa;
        int rn, wn;
        i_ctrl_read = 0; i_ctrl_write = 0; i_read_addr = '0; i_write_addr = '0;
        i_rd_num_trans = '0; i_wr_num_trans = '0; i_wr_data = '0;
        i_arready = 0; i_rvalid = 0; i_rlast = 0; i_rresp = 0; i_rdata = '0; i_rd_data_rdy = 0;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        ar_mode = 0; r_mode = 0; aw_mode = 0; w_mode = 0; b_mode = 0;
        rlast_inj = -1; rresp_inj = -1; bresp_inj = 2'b00; w_idx_mode = 0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset:arvalid", o_arvalid, 0);
        chk("reset:awvalid", o_awvalid, 0);
        chk("reset:wvalid", o_wvalid, 0);
        chk("reset:bready", o_bready, 0);
        chk("reset:req", o_indata_req_wr, 0);
        chk("reset:dones", {o_read_done, o_write_done}, 0);
        chk("reset:busy", {o_rd_busy, o_wr_busy}, 0);
        chk("reset:errs", {o_rd_err, o_wr_err}, 0);
        chk("reset:araddr", o_araddr, 0);
        chk("reset:axsize", {o_arsize, o_awsize}, {3'd2, 3'd2});
        chk("reset:axburst", {o_arburst, o_awburst}, 4'b0101);
        chk("reset:wstrb", o_wstrb, 4'hf);
        chk("reset:states", {o_rd_state, o_wr_state}, 0);
        @(negedge clk);
        rstn = 1;

        // single 16-beat read, everything ready
        setup(0, 0, 0, 0, 0);
        rb = rd_done_cnt;
        send_cmd(1, 32'h1000_0000, 16, 0, '0, 0);
        wait_done(rb, 0, 1, 0);
        check_read("rd16", 32'h1000_0000, 16, 1'b0, rb);

        // 40-beat read split into 16/16/8 with downstream stalls
        setup(1, 1, 0, 0, 0);
        rb = rd_done_cnt;
        send_cmd(1, 32'h1000_0000, 40, 0, '0, 0);
        wait_done(rb, 0, 1, 0);
        check_read("rd40", 32'h1000_0000, 40, 1'b0, rb);

        // 16-beat write, data = beat index, wready every other cycle
        setup(0, 0, 0, 1, 0);
        w_idx_mode = 1;
        wb = wr_done_cnt;
        send_cmd(0, '0, 0, 1, 32'h2000_0000, 16);
        wait_done(0, wb, 0, 1);
        check_write("wr16", 32'h2000_0000, 16, 1'b0, wb);

        // read with rresp error on beat 5 and early rlast on beat 10
        setup(0, 1, 0, 0, 0);
        rresp_inj = 4; rlast_inj = 9;
        rb = rd_done_cnt;
        send_cmd(1, 32'h1000_1000, 16, 0, '0, 0);
        wait_done(rb, 0, 1, 0);
        check_read("rd_err", 32'h1000_1000, 16, 1'b1, rb);

        // write with SLVERR response, then a clean write clears the flag
        setup(0, 0, 1, 2, 1);
        bresp_inj = 2'b10;
        wb = wr_done_cnt;
        send_cmd(0, '0, 0, 1, 32'h2000_1000, 20);
        wait_done(0, wb, 0, 1);
        check_write("wr_err", 32'h2000_1000, 20, 1'b1, wb);
        setup(0, 0, 0, 0, 0);
        wb = wr_done_cnt;
        send_cmd(0, '0, 0, 1, 32'h2000_2000, 4);
        #1;
        chk("wr_err_cleared_on_cmd", o_wr_err, 0);
        wait_done(0, wb, 0, 1);
        check_write("wr_after_err", 32'h2000_2000, 4, 1'b0, wb);

        // a second read command mid-burst is ignored
        setup(1, 1, 0, 0, 0);
        rb = rd_done_cnt;
        send_cmd(1, 32'h3000_0000, 20, 0, '0, 0);
        repeat (6) @(negedge clk);
        send_cmd(1, 32'h4444_0000, 7, 0, '0, 0);
        wait_done(rb, 0, 1, 0);
        repeat (10) @(negedge clk);
        #2;
        check_read("rd_ignore", 32'h3000_0000, 20, 1'b0, rb);

        // zero-length commands on both planes at once
        setup(0, 0, 0, 0, 0);
        rb = rd_done_cnt; wb = wr_done_cnt;
        send_cmd(1, 32'h5000_0000, 0, 1, 32'h6000_0000, 0);
        wait_done(rb, wb, 1, 1);
        check_read("rd_zero", 32'h5000_0000, 0, 1'b0, rb);
        check_write("wr_zero", 32'h6000_0000, 0, 1'b0, wb);

        // randomized concurrent read+write commands, first one wraps the address space
        for (int it = 0; it < 4; it++) begin
            setup(1, 1, 1, 2, 1);
            ra = (it == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFFC);
            wa = (it == 0) ? 32'hFFFF_FF80 : ($urandom & 32'hFFFF_FFFC);
            rn = $urandom_range(1, 45);
            wn = $urandom_range(1, 45);
            rb = rd_done_cnt; wb = wr_done_cnt;
            send_cmd(1, ra, rn, 1, wa, wn);
            wait_done(rb, wb, 1, 1);
            check_read("rd_rand", ra, rn, 1'b0, rb);
            check_write("wr_rand", wa, wn, 1'b0, wb);
        end

        // reset asserted while a write burst is on the W channel
        setup(0, 0, 0, 2, 1);
        wb = wr_done_cnt;
        send_cmd(0, '0, 0, 1, 32'h7000_0000, 30);
        begin
            int k = 0;
            while (k < 200 && !o_wvalid) begin
                @(negedge clk);
                #2;
                k++;
            end
            chk("midw:wvalid_reached", 64'(k < 200), 1);
        end
        rstn = 0;
        #1;
        chk("midw:valids_low", {o_arvalid, o_awvalid, o_wvalid, o_rd_data_vld, o_bready, o_indata_req_wr}, 0);
        chk("midw:busy_low", {o_rd_busy, o_wr_busy}, 0);
        repeat (3) @(negedge clk);
        rstn = 1;
        repeat (8) @(negedge clk);
        #2;
        chk("midw:no_done", wr_done_cnt - wb, 0);
        chk("midw:idle_after", o_wr_busy, 0);

        // engine still usable after the abandoned command
        setup(0, 0, 0, 0, 0);
        wb = wr_done_cnt;
        send_cmd(0, '0, 0, 1, 32'h7100_0000, 5);
        wait_done(0, wb, 0, 1);
        check_write("wr_post_reset", 32'h7100_0000, 5, 1'b0, wb);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_dma_burst_engine.md
Name: axi_dma_burst_engine

Overview:
AXI4 master burst engine that executes block-transfer commands issued by the DMA controller. A read command (pulse, address, beat count) becomes one or more INCR AR bursts; R data is streamed out, and a done pulse follows the final beat. A write command becomes AW/W/B bursts, with write data pulled beat-by-beat from the local buffer through a request/data handshake. The read and write planes are independent and may run concurrently; the block sits between the DMA controller and the AXI interconnect.

Parameters:
AXI_WIDTH_AD, 32, address width.
AXI_WIDTH_DA, 32, data width; bytes/beat BPB=AXI_WIDTH_DA/8; AxSIZE=log2(BPB).
BIT_TRANS, 18, width of beat-count inputs.
MAX_BURST_LEN, 16, max beats per AXI burst (1..256).

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
i_ctrl_read  in  1  read command pulse
i_read_addr  in  AXI_WIDTH_AD  read start byte address (sampled with i_ctrl_read)
i_rd_num_trans  in  BIT_TRANS  read beats (sampled with i_ctrl_read)
o_read_done  out  1  read command complete, 1-cycle pulse
o_rd_busy  out  1  read plane not IDLE
o_rd_data  out  AXI_WIDTH_DA  read data (=i_rdata)
o_rd_data_vld  out  1  read beat valid
i_rd_data_rdy  in  1  downstream ready for read beat
o_rd_err  out  1  sticky read error
i_ctrl_write  in  1  write command pulse
i_write_addr  in  AXI_WIDTH_AD  write start byte address
i_wr_num_trans  in  BIT_TRANS  write beats
o_indata_req_wr  out  1  write-data request, 1 pulse per beat
i_wr_data  in  AXI_WIDTH_DA  write data, valid the cycle after o_indata_req_wr
o_write_done  out  1  write command complete, 1-cycle pulse
o_wr_busy  out  1  write plane not IDLE
o_wr_err  out  1  sticky write error
o_araddr/o_arlen[7:0]/o_arsize[2:0]/o_arburst[1:0]/o_arvalid  out; i_arready  in  AXI AR
i_rdata/i_rresp[1:0]/i_rlast/i_rvalid  in; o_rready  out  AXI R
o_awaddr/o_awlen/o_awsize/o_awburst/o_awvalid  out; i_awready  in  AXI AW
o_wdata/o_wstrb(all ones)/o_wlast/o_wvalid  out; i_wready  in  AXI W
i_bresp[1:0]/i_bvalid  in; o_bready  out  AXI B

Behaviour:
- Reset: all outputs 0 except constants (AxSIZE, AxBURST=2'b01, WSTRB all ones). FSMs go to IDLE; counters and address regs are cleared.
- Reset mid-operation: valids drop immediately; no done pulse is issued; the outstanding command is abandoned.
- A command pulse while its plane is not IDLE is ignored (no queuing).
- Burst sizing: len=min(remaining, MAX_BURST_LEN); AxLEN=len-1. After each burst, addr+=len*BPB and remaining-=len. Address arithmetic wraps modulo 2^AXI_WIDTH_AD. No 4KB splitting: the controller guarantees alignment.
- num_trans==0: no AXI traffic; the done pulse is issued the cycle after the command.
- Read FSM: IDLE -> AR on accepted i_ctrl_read (latch addr/count, clear o_rd_err).
  - AR: o_arvalid=1, held with stable fields until i_arready; then go to R.
  - R: o_rready=i_rd_data_rdy, o_rd_data_vld=i_rvalid, o_rd_data=i_rdata (combinational pass-through). A beat counts when i_rvalid&o_rready.
  - On the len-th beat: if remaining>0 go to AR, else go to DONE.
  - DONE: o_read_done=1 for one cycle (cycle after the final beat), then IDLE.
  - Outside R: o_rready=0, o_rd_data_vld=0.
- Write FSM: IDLE -> AW on accepted i_ctrl_write (clear o_wr_err).
  - AW: o_awvalid until i_awready, then WREQ.
  - WREQ: o_indata_req_wr=1 one cycle, then WCAP.
  - WCAP: register i_wr_data into o_wdata; o_wvalid=1 from next cycle; go to WSEND.
  - WSEND: hold o_wvalid/o_wdata/o_wlast until i_wready. o_wlast=1 on the len-th beat. Then WREQ, or BWAIT after the last beat.
  - BWAIT: o_bready=1 until i_bvalid; then AW if remaining>0, else DONE.
  - DONE: o_write_done=1 one cycle, then IDLE.
  - Throughput: 3 cycles/beat minimum; exactly len req pulses per burst.
- Errors: o_rd_err is set by any rresp!=0, by rlast=1 before the len-th beat, or by rlast=0 on the len-th beat; the beat counter (not rlast) ends the burst. o_wr_err is set by bresp!=0. Both are sticky until the next accepted command of the same plane.
- Simultaneous i_ctrl_read and i_ctrl_write: both accepted; the planes share no state.

Test Plan:
1. Read 16 beats @0x1000_0000, arready/rvalid/rd_rdy always 1 -> single AR: araddr=0x1000_0000, arlen=15, arsize=2; 16 beats out; o_read_done one cycle after beat 16; o_rd_err=0.
2. Read 40 beats @0x1000_0000, MAX_BURST_LEN=16 -> ARs at 0x...000/0x...040/0x...080 with arlen 15/15/7; exactly one o_read_done; i_rd_data_rdy toggling stalls beats with no loss.
3. Write 16 beats @0x2000_0000, i_wr_data=beat index, i_wready every other cycle -> awlen=15; 16 req pulses; W data 0..15 in order; wlast only on beat 16; o_write_done one cycle after bvalid.
4. Read 16 beats with rlast on beat 10 and rresp=2 on beat 5 -> o_rd_err=1; 16 beats still consumed; done issued. Write with bresp=2 -> o_wr_err=1; next i_ctrl_write clears it.
5. i_ctrl_read again mid-burst -> ignored (one AR only). Concurrent read+write commands in the same cycle -> both complete independently. rstn low mid-W -> all valids 0 immediately; no done pulse.
6. num_trans=0 read and write -> done pulses the next cycle; arvalid/awvalid never asserted.
